// File: rtl/dot_product_ctrl_pkg.sv
// Shared types and default widths for the dot-product controller.
// Imported by the interface, controller and MAC datapath.
package dot_product_ctrl_pkg;

  localparam int DP_DATA_W = 16;
  localparam int DP_ACC_W  = 32;
  localparam int DP_LEN_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/dot_product_ctrl_if.sv
// Command, operand and result handshakes of the dot-product controller.
// The master drives commands/operands; the slave is the controller.
interface dot_product_ctrl_if
  import dot_product_ctrl_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ACC_W  = DP_ACC_W,
  parameter int LEN_W  = DP_LEN_W
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [LEN_W-1:0]         cmd_len;
  logic                     abort;
  logic                     op_valid;
  logic                     op_ready;
  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [ACC_W-1:0]  res_data;
  logic                     busy;

  modport master (
    output cmd_valid, cmd_len, abort,
    output op_valid, op_a, op_b,
    output res_ready,
    input  cmd_ready, op_ready,
    input  res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, abort,
    input  op_valid, op_a, op_b,
    input  res_ready,
    output cmd_ready, op_ready,
    output res_valid, res_data, busy
  );

endinterface

// File: rtl/dot_product_ctrl_mac.sv
// Signed multiply-accumulate; rst (active-low) clears the sum.
// Sum wraps modulo 2^ACC_W, one cycle after en.
module dot_product_ctrl_mac
  import dot_product_ctrl_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ACC_W  = DP_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] A,
  input  logic signed [DATA_W-1:0] B,
  output logic signed [ACC_W-1:0]  out
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = A * B;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else if (en) begin
      out <= out + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product controller: one FSM plus a beat down-counter
// sequencing a single MAC through clear, accumulate and result.
module dot_product_ctrl
  import dot_product_ctrl_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ACC_W  = DP_ACC_W,
  parameter int LEN_W  = DP_LEN_W
) (
  input logic         clk,
  input logic         rst,
  dot_product_ctrl_if.slave io
);

  state_e             state;
  state_e             nxt;
  logic [LEN_W-1:0]   cnt;
  logic               clr;
  logic               cmd_hs;
  logic               op_hs;
  logic               res_hs;
  logic               mac_en;
  logic               mac_rst;
  logic signed [ACC_W-1:0] acc;

  assign io.cmd_ready = (state == S_IDLE);
  assign io.op_ready  = (state == S_ACCUM) & ~io.abort;
  assign io.res_valid = (state == S_DONE) & ~io.abort;
  assign io.res_data  = acc;
  assign io.busy      = (state != S_IDLE);

  assign cmd_hs = io.cmd_valid & io.cmd_ready;
  assign op_hs  = io.op_valid & io.op_ready;
  assign res_hs = io.res_valid & io.res_ready;
  assign mac_en = op_hs;

  always_comb begin
    nxt = state;
    if (io.abort && state != S_IDLE) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (cmd_hs) nxt = S_CLEAR;
        S_CLEAR: nxt = (cnt == '0) ? S_DRAIN
                                   : S_ACCUM;
        S_ACCUM: if (op_hs && cnt == LEN_W'(1))
                   nxt = S_DRAIN;
        S_DRAIN: nxt = S_DONE;
        S_DONE:  if (res_hs) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // clr is a flop so the MAC clear never sees decode glitches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      clr   <= 1'b0;
    end else begin
      state <= nxt;
      clr   <= (nxt == S_CLEAR);
      if (cmd_hs) begin
        cnt <= io.cmd_len;
      end else if (op_hs) begin
        cnt <= cnt - LEN_W'(1);
      end
    end
  end

  assign mac_rst = rst & ~clr;

  dot_product_ctrl_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) mac (
    .clk(clk),
    .rst(mac_rst),
    .en (mac_en),
    .A  (io.op_a),
    .B  (io.op_b),
    .out(acc)
  );

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Scoreboard bench for dot_product_ctrl: stimulus pushes expected
// results, a monitor pops them on each result handshake.
module tb_dot_product_ctrl;
  import dot_product_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  dot_product_ctrl_if #(
    .DATA_W(DP_DATA_W),
    .ACC_W (DP_ACC_W),
    .LEN_W (DP_LEN_W)
  ) bus ();

  dot_product_ctrl #(
    .DATA_W(DP_DATA_W),
    .ACC_W (DP_ACC_W),
    .LEN_W (DP_LEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int applied = 0;
  int errs    = 0;
  int cyc     = 0;
  int en_cnt  = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    applied++;
    errs++;
    $display("FAIL %s: timed out", nm);
  endtask

  logic pv = 1'b0;
  logic hold_bad = 1'b0;
  logic cr_bad = 1'b0;
  int first = 0;
  logic [31:0] held = '0;

  always @(negedge clk) begin
    exp_t e;
    if (dut.mac_en) en_cnt++;
    if (rst && bus.res_valid) begin
      if (!pv) begin
        first    = cyc;
        held     = bus.res_data;
        hold_bad = 1'b0;
        cr_bad   = 1'b0;
      end else if (bus.res_data !== held) begin
        hold_bad = 1'b1;
      end
      if (bus.cmd_ready) cr_bad = 1'b1;
      if (bus.res_ready) begin
        if (sb.size() == 0) begin
          applied++;
          errs++;
          $display("FAIL spurious_res: got %0d expected none",
                   $signed(bus.res_data));
        end else begin
          e = sb.pop_front();
          chk("res_data", $signed(bus.res_data), e.data);
          chk("latency", first, e.cyc);
          chk("res_stable", hold_bad, 0);
          chk("cmd_ready_low", cr_bad, 0);
        end
      end
      pv = !bus.res_ready;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic cmd(input int n, output int t);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = DP_LEN_W'(n);
    t = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) tmo("cmd_accept");
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic ops(input int n,
                     input int a[4],
                     input int b[4],
                     input bit gap);
    bit ok;
    for (int i = 0; i < n; i++) begin
      bus.op_valid = 1'b1;
      bus.op_a = DP_DATA_W'(a[i]);
      bus.op_b = DP_DATA_W'(b[i]);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (bus.op_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) tmo("op_accept");
      @(posedge clk);
      #1;
      if (gap && i < n - 1) begin
        bus.op_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      tmo("result");
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_op_ready", bus.op_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_busy", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int t;
    int e0;
    bit seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b1;
    #12;
    chk_reset_outs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    cmd(3, t);
    sb.push_back('{33, t + 6});
    ops(3, '{1, 3, 5, 0}, '{2, 2, 5, 0}, 1'b0);
    drain();

    e0 = en_cnt;
    cmd(4, t);
    sb.push_back('{38, t + 10});
    ops(4, '{5, 2, 4, -2}, '{8, 3, -3, -2}, 1'b1);
    drain();
    chk("mac_enables", en_cnt - e0, 4);

    bus.res_ready = 1'b0;
    cmd(4, t);
    sb.push_back('{29, t + 7});
    ops(4, '{1, 0, 4, 10}, '{-1, 5, -5, 5}, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) tmo("res_valid_wait");
    repeat (5) @(posedge clk);
    #1 bus.res_ready = 1'b1;
    drain();

    cmd(0, t);
    sb.push_back('{0, t + 3});
    drain();

    cmd(4, t);
    ops(2, '{1, 2, 0, 0}, '{1, 2, 0, 0}, 1'b0);
    bus.abort    = 1'b1;
    bus.op_valid = 1'b1;
    @(negedge clk);
    chk("abort_op_ready", bus.op_ready, 0);
    @(posedge clk);
    #1;
    bus.abort    = 1'b0;
    bus.op_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_acc_kept", bus.res_data, 5);
    repeat (4) @(posedge clk);
    #1;
    cmd(2, t);
    sb.push_back('{-20, t + 5});
    ops(2, '{7, 1, 0, 0}, '{-3, 1, 0, 0}, 1'b0);
    drain();

    cmd(3, t);
    ops(2, '{3, 1, 0, 0}, '{3, 1, 0, 0}, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_reset_outs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cmd(1, t);
    sb.push_back('{1073741824, t + 4});
    ops(1, '{-32768, 0, 0, 0}, '{-32768, 0, 0, 0}, 1'b0);
    drain();

    cmd(2, t);
    sb.push_back('{int'(32'h8000_0000), t + 5});
    ops(2, '{-32768, -32768, 0, 0},
           '{-32768, -32768, 0, 0}, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, errs);
    $finish;
  end

endmodule
